seq_window_monitor: RTL and testbench
=====================================

# seq_window_monitor

Synthesizable multi-channel checker for the sequence `x ##[MIN_DLY:MAX_DLY] y`, evaluated on rising `clk`. It mirrors the meaning of the per-channel cover property in hardware and keeps a saturating hit counter per channel. Each cycle where `x` is high starts an attempt, and overlapping attempts are tracked independently. The block sits beside assertion test fixtures as a reference model that benches compare against simulator cover counts.

## Interface
- `CH`, default 4: number of independent channels.
- `MIN_DLY`, default 1: minimum cycle delay from `x` to `y`; legal range 1..`MAX_DLY`.
- `MAX_DLY`, default 4: maximum cycle delay; legal range `MIN_DLY`..16.
- `CNT_W`, default 16: width of each per-channel hit counter.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: synchronous reset, active-high.
- `en` input 1: launch enable; when low, no new attempts start.
- `clr` input 1: synchronous clear of pending attempts and counters.
- `x` input CH: per-channel sequence start.
- `y` input CH: per-channel sequence end.
- `match` output CH: one-cycle pulse when at least one attempt on the channel completes.
- `miss` output CH: one-cycle pulse when an attempt expires unmatched.
- `hit_cnt` output CH*CNT_W: flattened counters; channel i occupies bits [i*CNT_W +: CNT_W].
- `sat` output CH: sticky flag, set when a channel counter saturates.

## Operation
- Per channel, keep a pending vector `pend[1..MAX_DLY]`. `pend[k]` = 1 means an attempt launched k cycles ago is still open.
- Each cycle, the launch term is `x[i] & en`. It loads `pend[1]` on the next edge.
- Window test: `done[k] = pend[k] & y[i]` for k in [MIN_DLY, MAX_DLY]. Outside the window, `done[k]` = 0.
- Aging: `pend[k+1] <= pend[k] & ~done[k]` for k < MAX_DLY.
- Expiry: `pend[MAX_DLY] & ~y[i]` means that attempt expired.
- Completion uses first_match semantics: an attempt completes at the first in-window `y`, then it is retired.
- Several attempts may complete in one cycle.
- `hit_cnt[i]` increases by popcount(`done`), which ranges 0..MAX_DLY-MIN_DLY+1.
- The counter saturates at all-ones and never wraps. `sat[i]` is set on saturation and stays set until `rst` or `clr`.
- `match[i]` is registered from OR(`done`). `miss[i]` is registered from the expiry term.
- When `en` is low, new launches are blocked. Attempts already pending keep aging and can still match or miss.
- `clr` zeroes `pend`, `hit_cnt` and `sat`, and forces `match` and `miss` low on the next edge. Matches and launches in the `clr` cycle are discarded.
- Priority order: `rst` > `clr` > normal update.
- Channels are fully independent. There is no cross-channel state.

## Timing
- Reset values: `match` = 0, `miss` = 0, `hit_cnt` = 0, `sat` = 0, all `pend` = 0.
- Latency:
  - `x` sampled at edge t and `y` sampled at edge t+k, with k in window, gives `match` high during cycle t+k+1.
  - The counter shows the new value in that same cycle.
- Expiry: `x` at t with no `y` at t+MIN_DLY..t+MAX_DLY gives `miss` high during cycle t+MAX_DLY+1.
- Simultaneous `x` and `y` on a channel: the `y` serves older pending attempts only. The new attempt starts at age 1 next cycle, so it never matches itself. Zero delay is illegal.
- `rst` or `clr` mid-sequence: all open attempts are dropped and never produce `match` or `miss`.
- Throughput: one launch per channel per cycle, with no back-pressure.

## Configuration
- `SEQ_WINDOW_MONITOR_ASSERT_EN` defined:
  - A generate loop compiles in a concurrent `cover property (@(posedge clk) disable iff (rst) x[i] ##[MIN_DLY:MAX_DLY] y[i])` per channel.
  - It also compiles in `assert property`: `hit_cnt[i]` never decreases except across `rst` or `clr`.
  - It also compiles in `assert property`: `match[i]` implies that `y[i]` was high in the previous cycle.
- Macro absent: pure synthesizable RTL with identical ports and identical cycle behaviour, and no SVA constructs emitted.

## Test plan
All scenarios use CH=4, MIN_DLY=1, MAX_DLY=4, CNT_W=8.
- Single match: ch0 `x`=1 at cycle 2, `y`=1 at cycle 3 -> `match[0]`=1 at cycle 4 only, `hit_cnt[0]`=1, other channels stay 0.
- Overlap: ch1 `x` at cycles 2 and 3, `y` at cycle 5 -> both attempts complete, single `match[1]` pulse at cycle 6, `hit_cnt[1]`=2.
- Expiry and window edge: ch2 `x` at 10, no `y` until 15 -> `miss[2]` at 15, and `y` at 15 adds no count. Separately, `x` at 20 with `y` at 24 -> `match[2]` at 25.
- Saturation: drive ch3 `x`=`y`=1 continuously for 300 cycles -> `hit_cnt[3]` holds 255, `sat[3]`=1.
- Clear and reset mid-flight: `x` at 30, `clr` at 31, `y` at 32 -> no `match`, counters 0, `sat` cleared. Repeat with `rst` in place of `clr` -> same result, all outputs 0.
- Enable gating: `en`=0 with `x`=1 at 40 and `y` at 41 -> no match. A pending attempt from 39 still matches the `y` at 41 -> `match` at 42.

Source files
------------

// File: rtl/seq_window_monitor.sv
// Multi-channel hardware checker for x ##[MIN_DLY:MAX_DLY] y with saturating hit counters.
// Define SEQ_WINDOW_MONITOR_ASSERT_EN to compile in the matching cover/assert properties.
module seq_window_monitor #(
  parameter int CH      = 4,
  parameter int MIN_DLY = 1,
  parameter int MAX_DLY = 4,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                clr,
  input  logic [CH-1:0]       x,
  input  logic [CH-1:0]       y,
  output logic [CH-1:0]       match,
  output logic [CH-1:0]       miss,
  output logic [CH*CNT_W-1:0] hit_cnt,
  output logic [CH-1:0]       sat
);

  localparam int PW = $clog2(MAX_DLY - MIN_DLY + 2);
  localparam int SW = CNT_W + PW;
  localparam logic [SW-1:0] CNT_MAX = SW'({CNT_W{1'b1}});

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      logic [MAX_DLY:1] pend_reg;
      logic [MAX_DLY:1] pend_next;
      logic [MAX_DLY:1] done;
      logic [PW-1:0]    pop;
      logic [SW-1:0]    sum;
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;
      logic             sat_hit;
      logic             expire;
      logic             match_reg;
      logic             miss_reg;
      logic             sat_reg;

      always_comb begin
        done = '0;
        pop  = '0;
        for (int k = MIN_DLY; k <= MAX_DLY; k++) begin
          done[k] = pend_reg[k] & y[gi];
          pop     = pop + PW'(done[k]);
        end
      end

      // Attempts that complete are retired here, so each one counts once.
      always_comb begin
        pend_next    = '0;
        pend_next[1] = x[gi] & en;
        for (int k = 1; k < MAX_DLY; k++) begin
          pend_next[k+1] = pend_reg[k] & ~done[k];
        end
      end

      assign expire   = pend_reg[MAX_DLY] & ~y[gi];
      assign sum      = SW'(cnt_reg) + SW'(pop);
      assign sat_hit  = (sum >= CNT_MAX);
      assign cnt_next = sat_hit ? {CNT_W{1'b1}} : sum[CNT_W-1:0];

      always_ff @(posedge clk) begin
        if (rst || clr) begin
          pend_reg  <= '0;
          cnt_reg   <= '0;
          match_reg <= 1'b0;
          miss_reg  <= 1'b0;
          sat_reg   <= 1'b0;
        end else begin
          pend_reg  <= pend_next;
          cnt_reg   <= cnt_next;
          match_reg <= |done;
          miss_reg  <= expire;
          sat_reg   <= sat_reg | sat_hit;
        end
      end

      assign match[gi]                   = match_reg;
      assign miss[gi]                    = miss_reg;
      assign sat[gi]                     = sat_reg;
      assign hit_cnt[gi*CNT_W +: CNT_W]  = cnt_reg;

`ifdef SEQ_WINDOW_MONITOR_ASSERT_EN
      c_seq: cover property (@(posedge clk) disable iff (rst)
        x[gi] ##[MIN_DLY:MAX_DLY] y[gi]);

      a_cnt_mono: assert property (@(posedge clk) disable iff (rst)
        !clr |=> (hit_cnt[gi*CNT_W +: CNT_W] >= $past(hit_cnt[gi*CNT_W +: CNT_W])));

      a_match_y: assert property (@(posedge clk) disable iff (rst)
        match[gi] |-> $past(y[gi]));
`endif
    end
  endgenerate

endmodule

// File: tb/tb_seq_window_monitor.sv
// Scoreboard bench for seq_window_monitor: a launch-time model pushes expected outputs per cycle.
module tb_seq_window_monitor;
  localparam int CH = 4, MIN_DLY = 1, MAX_DLY = 4, CNT_W = 8;

  logic clk = 1'b0;
  logic rst, en, clr;
  logic [CH-1:0] x, y, match, miss, sat;
  logic [CH*CNT_W-1:0] hit_cnt;

  seq_window_monitor #(.CH(CH), .MIN_DLY(MIN_DLY), .MAX_DLY(MAX_DLY), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .x(x), .y(y),
    .match(match), .miss(miss), .hit_cnt(hit_cnt), .sat(sat)
  );

  always #5 clk = ~clk;

  wire [43:0] obs = {match, miss, sat, hit_cnt};

  int checks = 0;
  int errors = 0;
  int now = 0;
  logic [43:0] sb[$];
  logic [43:0] exp_v;

  // Reference model: open attempts are held as launch times; age = now - launch.
  int lq [CH][$];
  int cnt_m [CH];
  logic [CH-1:0] sat_m = '0;

  task automatic model_step();
    logic [CH-1:0] m, mi;
    logic [31:0] cv;
    m = '0; mi = '0;
    if (rst || clr) begin
      for (int c = 0; c < CH; c++) begin
        lq[c].delete();
        cnt_m[c] = 0;
      end
      sat_m = '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        int nq[$];
        int d;
        d = 0;
        foreach (lq[c][j]) begin
          int age;
          age = now - lq[c][j];
          if (y[c] && age >= MIN_DLY && age <= MAX_DLY) d++;
          else if (age == MAX_DLY) mi[c] = 1'b1;
          else nq.push_back(lq[c][j]);
        end
        if (x[c] && en) nq.push_back(now);
        lq[c] = nq;
        m[c] = (d > 0);
        cnt_m[c] = cnt_m[c] + d;
        if (cnt_m[c] >= 255) begin
          cnt_m[c] = 255;
          sat_m[c] = 1'b1;
        end
      end
    end
    for (int c = 0; c < CH; c++) cv[c*8 +: 8] = 8'(cnt_m[c]);
    sb.push_back({m, mi, sat_m, cv});
  endtask

  task automatic cyc(input logic [3:0] xv, input logic [3:0] yv, input logic env,
                     input logic clrv, input logic rstv);
    x = xv; y = yv; en = env; clr = clrv; rst = rstv;
    model_step();
    @(posedge clk); #1;
    now++;
  endtask

  task automatic test_reset();
    cyc(4'h0, 4'h0, 1'b1, 1'b0, 1'b1);
    cyc(4'h0, 4'h0, 1'b1, 1'b0, 1'b1);
    exp_v = sb.pop_front(); exp_v = sb.pop_front();
    checks++;
    if (obs !== 44'h0 || obs !== exp_v) begin
      errors++; $display("FAIL reset: got %h want %h", obs, 44'h0);
    end
    $display("reset: outputs %h", obs);
  endtask

  task automatic test_single_match();
    logic [3:0] xs [6] = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [3:0] ys [6] = '{4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
    cyc(4'h0, 4'h0, 1'b1, 1'b1, 1'b0);
    exp_v = sb.pop_front();
    for (int c = 0; c < 6; c++) begin
      cyc(xs[c], ys[c], 1'b1, 1'b0, 1'b0);
      exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL single c%0d: got %h want %h", c, obs, exp_v); end
      if (c == 1) begin
        checks++;
        if (match !== 4'b0001 || hit_cnt !== 32'h0000_0001) begin
          errors++; $display("FAIL single_pulse: got match %b cnt %h want 0001 00000001", match, hit_cnt);
        end
      end
    end
    $display("single_match: cnt %h", hit_cnt);
  endtask

  task automatic test_overlap();
    logic [3:0] xs [6] = '{4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [3:0] ys [6] = '{4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0};
    for (int c = 0; c < 6; c++) begin
      cyc(xs[c], ys[c], 1'b1, 1'b0, 1'b0);
      exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL overlap c%0d: got %h want %h", c, obs, exp_v); end
      if (c == 3) begin
        checks++;
        if (match !== 4'b0010 || hit_cnt[15:8] !== 8'd2) begin
          errors++; $display("FAIL overlap_pulse: got match %b cnt1 %0d want 0010 2", match, hit_cnt[15:8]);
        end
      end
    end
    $display("overlap: cnt %h", hit_cnt);
  endtask

  task automatic test_expiry();
    logic [3:0] xs [12] = '{4'h4, 0, 0, 0, 0, 0, 4'h4, 0, 0, 0, 0, 0};
    logic [3:0] ys [12] = '{0, 0, 0, 0, 0, 4'h4, 0, 0, 0, 0, 4'h4, 0};
    for (int c = 0; c < 12; c++) begin
      cyc(xs[c], ys[c], 1'b1, 1'b0, 1'b0);
      exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL expiry c%0d: got %h want %h", c, obs, exp_v); end
      if (c == 4) begin
        checks++;
        if (miss !== 4'b0100) begin errors++; $display("FAIL expiry_miss: got %b want 0100", miss); end
      end
      if (c == 5) begin
        checks++;
        if (match !== 4'b0000 || hit_cnt[23:16] !== 8'd0) begin
          errors++; $display("FAIL late_y: got match %b cnt2 %0d want 0000 0", match, hit_cnt[23:16]);
        end
      end
      if (c == 10) begin
        checks++;
        if (match !== 4'b0100 || hit_cnt[23:16] !== 8'd1) begin
          errors++; $display("FAIL edge_match: got match %b cnt2 %0d want 0100 1", match, hit_cnt[23:16]);
        end
      end
    end
    $display("expiry: miss seen, window edge cnt %0d", hit_cnt[23:16]);
  endtask

  task automatic test_saturation();
    for (int c = 0; c < 300; c++) begin
      cyc(4'h8, 4'h8, 1'b1, 1'b0, 1'b0);
      exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL sat c%0d: got %h want %h", c, obs, exp_v); end
    end
    checks++;
    if (hit_cnt[31:24] !== 8'd255 || sat !== 4'b1000) begin
      errors++; $display("FAIL saturation: got cnt3 %0d sat %b want 255 1000", hit_cnt[31:24], sat);
    end
    $display("saturation: cnt3 %0d sat %b", hit_cnt[31:24], sat);
  endtask

  task automatic test_clear_reset();
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 6; c++) begin
        cyc(c == 0 ? 4'hf : 4'h0, c == 2 ? 4'hf : 4'h0, 1'b1,
            (r == 0 && c == 1), (r == 1 && c == 1));
        exp_v = sb.pop_front(); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL clrrst r%0d c%0d: got %h want %h", r, c, obs, exp_v); end
      end
      checks++;
      if (obs !== 44'h0) begin errors++; $display("FAIL midflight r%0d: got %h want 0", r, obs); end
      $display("%s mid-flight: outputs %h", r == 0 ? "clr" : "rst", obs);
    end
  endtask

  task automatic test_enable_gating();
    logic [3:0] xs [10] = '{4'h1, 0, 0, 0, 0, 4'h1, 4'h1, 0, 0, 0};
    logic [3:0] ys [10] = '{0, 4'h1, 0, 0, 0, 0, 0, 4'h1, 0, 0};
    logic       es [10] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    for (int c = 0; c < 10; c++) begin
      cyc(xs[c], ys[c], es[c], 1'b0, 1'b0);
      exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL enable c%0d: got %h want %h", c, obs, exp_v); end
      if (c == 1) begin
        checks++;
        if (match !== 4'b0000) begin errors++; $display("FAIL gated: got match %b want 0000", match); end
      end
      if (c == 7) begin
        checks++;
        if (match !== 4'b0001 || hit_cnt[7:0] !== 8'd1) begin
          errors++; $display("FAIL pending_match: got match %b cnt0 %0d want 0001 1", match, hit_cnt[7:0]);
        end
      end
    end
    $display("enable_gating: cnt0 %0d", hit_cnt[7:0]);
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 400; c++) begin
      cyc(4'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 40) == 0), 1'b0);
      exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL random c%0d: got %h want %h", c, obs, exp_v); end
    end
    $display("back_to_back: final cnt %h sat %b", hit_cnt, sat);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; x = '0; y = '0;
    test_reset();
    test_single_match();
    test_overlap();
    test_expiry();
    test_saturation();
    test_clear_reset();
    test_enable_gating();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
